// File: rtl/picorv32_alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and shift latency.
// PICORV32_ALU_SHIFT4_EN selects 4-bit shift steps (shift_steps tracks the mode).
package picorv32_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SRA = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Number of SHIFT cycles needed for a shift amount n > 0.
    function automatic int shift_steps(input int n);
`ifdef PICORV32_ALU_SHIFT4_EN
        return (n / 4) + (n % 4);
`else
        return n;
`endif
    endfunction

endpackage

// File: rtl/picorv32_alu_shifter.sv
// Iterative shifter: loads source/amount/op, then moves one step per cycle.
// PICORV32_ALU_SHIFT4_EN enables 4-bit steps while at least 4 remain.
module picorv32_alu_shifter
    import picorv32_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       load,
    input  logic                       step,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           data_in,
    input  logic [$clog2(WIDTH)-1:0]   amt_in,
    output logic [WIDTH-1:0]           data_nxt,
    output logic                       last
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] ONE  = SW'(1);
    localparam logic [SW-1:0] FOUR = SW'(4);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]    cnt_q, cnt_d, cnt_nxt_s, stp_s;
    logic [2:0]       op_q, op_d;

    // Step size, post-step value/count and next register state.
    always_comb begin
`ifdef PICORV32_ALU_SHIFT4_EN
        stp_s = (cnt_q >= FOUR) ? FOUR : ONE;
`else
        stp_s = ONE;
`endif
        cnt_nxt_s = cnt_q - stp_s;
        last      = (cnt_nxt_s == '0);
        case (op_q)
            OP_SLL:  data_nxt = data_q << stp_s;
            OP_SRL:  data_nxt = data_q >> stp_s;
            OP_SRA:  data_nxt = $signed(data_q) >>> stp_s;
            default: data_nxt = data_q;
        endcase
        data_d = data_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        if (load) begin
            data_d = data_in;
            cnt_d  = amt_in;
            op_d   = op;
        end else if (step) begin
            data_d = data_nxt;
            cnt_d  = cnt_nxt_s;
        end else begin
            data_d = data_q;
        end
    end

    // Shift register, counter and mode flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q <= '0;
            cnt_q  <= '0;
            op_q   <= OP_SLL;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
        end
    end

endmodule

// File: rtl/picorv32_alu_seq.sv
// Sequential ALU responder: valid/ready request in, valid/ready response out.
// Shift step width is selected by PICORV32_ALU_SHIFT4_EN (see picorv32_alu_shifter).
module picorv32_alu_seq
    import picorv32_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_op1,
    input  logic [WIDTH-1:0] req_op2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d, exec_s;
    logic             req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, busy_q, busy_d;
    logic             sh_load_s, sh_step_s, sh_last_s, is_shift_s;
    logic [WIDTH-1:0] sh_data_nxt_s;
    logic [SW-1:0]    amt_s;

    picorv32_alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk      (clk),
        .resetn   (resetn),
        .load     (sh_load_s),
        .step     (sh_step_s),
        .op       (req_op),
        .data_in  (req_op1),
        .amt_in   (amt_s),
        .data_nxt (sh_data_nxt_s),
        .last     (sh_last_s)
    );

    // Single-cycle datapath; shift ops only reach EXEC with amount 0.
    always_comb begin
        case (op_q)
            OP_ADD:  exec_s = op1_q + op2_q;
            OP_SUB:  exec_s = op1_q - op2_q;
            OP_AND:  exec_s = op1_q & op2_q;
            OP_OR:   exec_s = op1_q | op2_q;
            OP_XOR:  exec_s = op1_q ^ op2_q;
            default: exec_s = op1_q;
        endcase
    end

    // FSM next state, operand capture and registered-output next values.
    always_comb begin
        amt_s      = req_op2[SW-1:0];
        is_shift_s = (req_op == OP_SLL) || (req_op == OP_SRL) || (req_op == OP_SRA);
        state_d    = state_q;
        op_d       = op_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        rsp_data_d = rsp_data_q;
        sh_load_s  = 1'b0;
        sh_step_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d  = req_op;
                    op1_d = req_op1;
                    op2_d = req_op2;
                    if (is_shift_s && (amt_s != '0)) begin
                        sh_load_s = 1'b1;
                        state_d   = ST_SHIFT;
                    end else begin
                        state_d   = ST_EXEC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_data_d = exec_s;
                state_d    = ST_DONE;
            end
            ST_SHIFT: begin
                sh_step_s = 1'b1;
                if (sh_last_s) begin
                    rsp_data_d = sh_data_nxt_s;
                    state_d    = ST_DONE;
                end else begin
                    state_d    = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, captured operands and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            op1_q       <= '0;
            op2_q       <= '0;
            rsp_data_q  <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            rsp_data_q  <= rsp_data_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_picorv32_alu_seq.sv
// Scoreboard bench for picorv32_alu_seq: driver pushes expected results, monitor pops and checks.
module tb_picorv32_alu_seq;
    import picorv32_alu_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_op1 = 32'd0;
    logic [31:0] req_op2 = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        busy;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          seen = 1'b0;
    logic [31:0] held;
    exp_t        exp_q[$];

    picorv32_alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: checks every response against the scoreboard and idle/busy status each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rsp_data", rsp_data, e.data);
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    end
                    seen = 1'b1;
                    held = rsp_data;
                end else begin
                    chk("rsp_stable", rsp_data, held);
                end
                chk("ready_in_done", {31'd0, req_ready}, 32'd0);
                chk("busy_in_done", {31'd0, busy}, 32'd1);
                if (rsp_ready) seen = 1'b0;
            end else begin
                chk("busy", {31'd0, busy}, {31'd0, exp_q.size() > 0});
                chk("req_ready", {31'd0, req_ready}, {31'd0, exp_q.size() == 0});
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit swap);
        exp_t e;
        int   guard;
        int   amt;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = op;
        req_op1   = a;
        req_op2   = b;
        guard     = 0;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("accept_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            amt       = int'(b[4:0]);
            e.data    = exp;
            e.acc     = cyc;
            e.lat     = (op >= OP_SLL && amt != 0) ? shift_steps(amt) : 1;
            exp_q.push_back(e);
            if (swap) begin
                req_op1 = b;
                req_op2 = a;
            end else begin
                req_op1 = 32'hDEAD_BEEF;
                req_op2 = 32'h0000_001F;
            end
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() > 0 || seen) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
        mon_en = 1'b1;

        // Directed arithmetic/logic and shift vectors.
        issue(OP_ADD, 32'd10, 32'd5, 32'd15, 1'b0);
        issue(OP_SUB, 32'd20, 32'd8, 32'd12, 1'b0);
        issue(OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
        issue(OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);
        issue(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0);
        issue(OP_OR,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0);
        issue(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0);
        issue(OP_SLL, 32'd4, 32'd2, 32'd16, 1'b0);
        issue(OP_SRL, 32'd4, 32'd2, 32'd1, 1'b0);
        issue(OP_SRA, 32'hFFFF_FFF0, 32'd2, 32'hFFFF_FFFC, 1'b0);
        issue(OP_SLL, 32'd1, 32'd31, 32'h8000_0000, 1'b0);
        issue(OP_SRL, 32'h8000_0000, 32'h0000_0025, 32'h0400_0000, 1'b0);
        issue(OP_SRA, 32'h8000_0000, 32'd20, 32'hFFFF_F800, 1'b0);
        issue(OP_SLL, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0);
        issue(OP_SRA, 32'h8000_0000, 32'h0000_0040, 32'h8000_0000, 1'b0);
        issue(OP_SRL, 32'hF000_0000, 32'd7, 32'h01E0_0000, 1'b1);
        drain();

        // Response backpressure for 5 cycles, then release.
        rsp_ready = 1'b0;
        issue(OP_ADD, 32'd7, 32'd8, 32'd15, 1'b0);
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);

        // Reset in the middle of a long shift.
        issue(OP_SRA, 32'h8000_0000, 32'd20, 32'hFFFF_F800, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_rsp_data", rsp_data, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        exp_q.delete();
        seen = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_midrst", {31'd0, req_ready}, 32'd1);
        mon_en = 1'b1;
        repeat (40) @(negedge clk);
        issue(OP_ADD, 32'd100, 32'd23, 32'd123, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
